user_ram_arbiter: RTL and testbench
===================================

# user_ram_arbiter

Two-port arbiter and access sequencer for the single-port 32-bit user RAM. It shares the RAM between port 0 (CPU native memory bus) and port 1 (Ring-LWE accelerator or DMA). Each port uses a valid/ready handshake. The block drives the RAM's `wr_en`/`rd_en`/`addr`/`di` controls and captures `do` for reads. Exactly one transaction is in flight at a time.

## Interface
- `ADDR_BIT`, default 8: RAM word-address width; must match the RAM instance.

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `p0_valid_i`  in  1  port 0 request.
- `p0_we_i`  in  1  port 0 write (1) / read (0).
- `p0_addr_i`  in  ADDR_BIT  port 0 word address.
- `p0_wdata_i`  in  32  port 0 write data.
- `p0_ready_o`  out  1  port 0 completion pulse.
- `p0_rdata_o`  out  32  port 0 read data, valid while `p0_ready_o`=1 on reads.
- `p1_valid_i`, `p1_we_i`, `p1_addr_i`, `p1_wdata_i`, `p1_ready_o`, `p1_rdata_o`: same as port 0, for port 1.
- `ram_wr_en_o`  out  1  RAM write enable.
- `ram_rd_en_o`  out  1  RAM read enable.
- `ram_addr_o`  out  ADDR_BIT  RAM address.
- `ram_di_o`  out  32  RAM write data.
- `ram_do_i`  in  32  RAM read data. It is registered inside the RAM and driven only while `ram_rd_en_o`=1.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ACCESS, CAPTURE, ACK. Encoding is free.
- **IDLE:**
  - Sample `p0_valid_i`/`p1_valid_i`. If neither is set, stay in IDLE.
  - Otherwise pick a winner by the arbitration rule. Latch the winner id, `we`, `addr` and `wdata` into internal registers, then go to ACCESS.
- **ACCESS:**
  - Write: `ram_wr_en_o`=1, `ram_addr_o`/`ram_di_o` from the latched values. Next state is ACK.
  - Read: `ram_rd_en_o`=1, `ram_addr_o` latched. Next state is CAPTURE.
- **CAPTURE (reads only):**
  - Hold `ram_rd_en_o`=1 and `ram_addr_o`.
  - Register `ram_do_i` into the winner's rdata register at the end of the cycle. Next state is ACK.
- **ACK:**
  - Assert the winner's `pX_ready_o`=1 for exactly one cycle. The loser's ready stays 0.
  - Record the winner as last-granted. Next state is IDLE.
- **RAM outputs:** `ram_wr_en_o` and `ram_rd_en_o` are never both 1. In every state where they are not driven as above, they are 0 and `ram_di_o`=0. `ram_addr_o` holds its last value.
- **Rdata:** `pX_rdata_o` holds its last captured value until the next read for that port. Writes do not modify it.
- **Requester contract:**
  - Hold `valid`/`we`/`addr`/`wdata` stable from assertion until the cycle `ready` is seen.
  - Deassert `valid` on or after that edge.
  - If `valid` drops early, the latched transaction still completes and `ready` still pulses.
- **Arbitration:** only IDLE arbitrates. A request arriving during ACCESS/CAPTURE/ACK waits; it is never dropped.
- **Reset, any state (including mid-transaction):**
  - State goes to IDLE.
  - All ready, enable, `busy_o`, `ram_di_o`, `ram_addr_o` and rdata outputs go to 0.
  - The last-granted pointer goes to port 1, so port 0 wins the first tie.
  - An aborted RAM write may or may not have landed. No ready is issued for it.

## Timing
- Request visible in IDLE at cycle 0:
  - Write: ACCESS in cycle 1 (`ram_wr_en_o` high), `ready` in cycle 2. Latency is 2 cycles.
  - Read: ACCESS in cycle 1, CAPTURE in cycle 2, `ready` and `rdata` in cycle 3. Latency is 3 cycles.
- At least one IDLE cycle separates transactions. Peak throughput is one write per 3 cycles or one read per 4 cycles.
- Maximum wait for a continuously requesting port, with round-robin enabled, is one foreign transaction plus its own: 8 cycles.

## Configuration
- **`USER_RAM_ARB_RR_EN` defined:** round-robin. When both ports are valid in IDLE, the port that was not last-granted wins. A single valid port always wins.
- **`USER_RAM_ARB_RR_EN` undefined:** fixed priority. Port 0 always wins a tie, so port 1 may starve. The last-granted pointer is not implemented.

## Test plan
- **Reset mid-read:** assert `rst_i` during CAPTURE → all outputs 0 and `busy_o`=0 within the same cycle. A fresh read afterwards completes normally.
- **Single write then read:** p0 write addr 0x05, data 0xDEADBEEF → `ram_wr_en_o` high in cycle 1 and `p0_ready_o` in cycle 2. Then p0 read 0x05 → `p0_ready_o` in cycle 3 with `p0_rdata_o`=0xDEADBEEF.
- **Simultaneous requests, round-robin enabled:** both ports continuously request reads of 0x10/0x20 after reset → grants alternate p0, p1, p0, p1, with no port granted twice in a row.
- **Simultaneous requests, round-robin undefined:** same stimulus → p0 granted every transaction. p1 is granted only after p0 drops valid.
- **Late arrival:** p1 requests a write of 0x12345678 to 0xFF while p0's read is in CAPTURE → p1 is not granted until the IDLE after p0's ACK. `ram_wr_en_o` and `ram_rd_en_o` are never high together.

Source files
------------

// File: rtl/user_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : user_ram_arbiter
//  Purpose  : Two-port valid/ready arbiter and access sequencer for the
//             single-port 32-bit user RAM (port 0 = CPU, port 1 = accel/DMA).
//             One transaction in flight: IDLE -> ACCESS [-> CAPTURE] -> ACK.
//  Options  : `define USER_RAM_ARB_RR_EN selects round-robin arbitration on
//             ties; otherwise port 0 has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module user_ram_arbiter #(
    parameter int ADDR_BIT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                p0_valid_i,
    input  logic                p0_we_i,
    input  logic [ADDR_BIT-1:0] p0_addr_i,
    input  logic [31:0]         p0_wdata_i,
    output logic                p0_ready_o,
    output logic [31:0]         p0_rdata_o,
    input  logic                p1_valid_i,
    input  logic                p1_we_i,
    input  logic [ADDR_BIT-1:0] p1_addr_i,
    input  logic [31:0]         p1_wdata_i,
    output logic                p1_ready_o,
    output logic [31:0]         p1_rdata_o,
    output logic                ram_wr_en_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_BIT-1:0] ram_addr_o,
    output logic [31:0]         ram_di_o,
    input  logic [31:0]         ram_do_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_win;      // 0 = port 0 owns the transaction, 1 = port 1
    logic                  r_we;
    logic [ADDR_BIT-1:0]   r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata0;
    logic [31:0]           r_rdata1;
    logic                  w_any;
    logic                  w_grant_p1;

    assign w_any = p0_valid_i | p1_valid_i;

`ifdef USER_RAM_ARB_RR_EN
    logic r_last;   // port granted most recently; resets to 1 so port 0 wins the first tie

    // Tie goes to the port not granted last; a lone requester always wins
    always_comb begin
        w_grant_p1 = ~p0_valid_i;
        if (p0_valid_i && p1_valid_i) begin
            w_grant_p1 = ~r_last;
        end
    end

    // Record the winner when its transaction completes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (r_state == S_ACK) begin
            r_last <= r_win;
        end
    end
`else
    // Fixed priority: port 1 is granted only when port 0 is idle
    assign w_grant_p1 = ~p0_valid_i;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; only IDLE looks at the request lines
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_next = S_ACCESS;
            S_ACCESS:  w_next = r_we ? S_ACK : S_CAPTURE;
            S_CAPTURE: w_next = S_ACK;
            S_ACK:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Latch the winning request so early valid drop cannot disturb it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_win   <= w_grant_p1;
            r_we    <= w_grant_p1 ? p1_we_i    : p0_we_i;
            r_addr  <= w_grant_p1 ? p1_addr_i  : p0_addr_i;
            r_wdata <= w_grant_p1 ? p1_wdata_i : p0_wdata_i;
        end
    end

    // Capture RAM read data into the owner's rdata register at end of CAPTURE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == S_CAPTURE) begin
            if (r_win) begin
                r_rdata1 <= ram_do_i;
            end else begin
                r_rdata0 <= ram_do_i;
            end
        end
    end

    // RAM controls decoded from state; r_addr keeps the address stable between accesses
    assign ram_wr_en_o = (r_state == S_ACCESS) &&  r_we;
    assign ram_rd_en_o = ((r_state == S_ACCESS) || (r_state == S_CAPTURE)) && !r_we;
    assign ram_di_o    = ram_wr_en_o ? r_wdata : 32'd0;
    assign ram_addr_o  = r_addr;

    assign p0_ready_o  = (r_state == S_ACK) && !r_win;
    assign p1_ready_o  = (r_state == S_ACK) &&  r_win;
    assign p0_rdata_o  = r_rdata0;
    assign p1_rdata_o  = r_rdata1;
    assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_user_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_ram_arbiter
//  Purpose  : Self-checking bench for user_ram_arbiter: directed vector table,
//             multi-cycle corner sequences and randomized transactions
//             compared with a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_user_ram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        p0_valid_i, p0_we_i, p1_valid_i, p1_we_i;
    logic [7:0]  p0_addr_i, p1_addr_i;
    logic [31:0] p0_wdata_i, p1_wdata_i;
    logic        p0_ready_o, p1_ready_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        ram_wr_en_o, ram_rd_en_o, busy_o;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_di_o;
    logic [31:0] ram_do_i;

    int checks = 0;
    int fails  = 0;

    // Behavioural RAM attached to the DUT (registered read, data only while rd_en)
    logic [31:0] ram_mem [256];
    // Reference model state
    logic [31:0] m_mem   [256];
    logic [31:0] m_rdata [2];
    int          m_last;

    typedef struct {
        bit          v0;  bit we0; logic [7:0] a0; logic [31:0] d0;
        bit          v1;  bit we1; logic [7:0] a1; logic [31:0] d1;
        int          win; int lat; logic [31:0] rd;
    } vec_t;
    vec_t tbl [10];

    user_ram_arbiter #(.ADDR_BIT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_valid_i(p0_valid_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_ready_o(p0_ready_o), .p0_rdata_o(p0_rdata_o),
        .p1_valid_i(p1_valid_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_ready_o(p1_ready_o), .p1_rdata_o(p1_rdata_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_rd_en_o(ram_rd_en_o), .ram_addr_o(ram_addr_o),
        .ram_di_o(ram_di_o), .ram_do_i(ram_do_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ram_wr_en_o) ram_mem[ram_addr_o] <= ram_di_o;
        ram_do_i <= ram_rd_en_o ? ram_mem[ram_addr_o] : 32'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enable exclusivity is checked every cycle, away from the clock edge
    always @(negedge clk_i) begin
        if (rst_i === 1'b0) check("wr_rd_exclusive", {31'd0, ram_wr_en_o & ram_rd_en_o}, 32'd0);
    end

    // Arbitration rule of the reference model
    function automatic int model_winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef USER_RAM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic drive(input bit v0, input bit we0, input logic [7:0] a0, input logic [31:0] d0,
                         input bit v1, input bit we1, input logic [7:0] a1, input logic [31:0] d1);
        p0_valid_i = v0; p0_we_i = we0; p0_addr_i = a0; p0_wdata_i = d0;
        p1_valid_i = v1; p1_we_i = we1; p1_addr_i = a1; p1_wdata_i = d1;
    endtask

    task automatic model_reset();
        m_last     = 1;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
    endtask

    // One arbitrated transaction starting in IDLE (called 1 time unit after a rising edge)
    task automatic run_txn(input vec_t v, input string name);
        bit          got = 0;
        int          k   = 0;
        bit          we  = (v.win == 1) ? v.we1 : v.we0;
        logic [7:0]  a   = (v.win == 1) ? v.a1  : v.a0;
        logic [31:0] d   = (v.win == 1) ? v.d1  : v.d0;
        drive(v.v0, v.we0, v.a0, v.d0, v.v1, v.we1, v.a1, v.d1);
        while (!got && k < 8) begin
            @(posedge clk_i); #1; k++;
            if (k == 1) begin
                check({name, ".wr_en"}, {31'd0, ram_wr_en_o}, {31'd0, we});
                check({name, ".rd_en"}, {31'd0, ram_rd_en_o}, {31'd0, !we});
                check({name, ".addr"},  {24'd0, ram_addr_o}, {24'd0, a});
                check({name, ".di"},    ram_di_o, we ? d : 32'd0);
                check({name, ".busy"},  {31'd0, busy_o}, 32'd1);
            end
            if (k == 2 && !we) begin
                check({name, ".capture_rd_en"}, {31'd0, ram_rd_en_o}, 32'd1);
            end
            if (p0_ready_o || p1_ready_o) begin
                got = 1;
                check({name, ".latency"}, k, v.lat);
                check({name, ".p0_ready"}, {31'd0, p0_ready_o}, {31'd0, v.win == 0});
                check({name, ".p1_ready"}, {31'd0, p1_ready_o}, {31'd0, v.win == 1});
                if (we) m_mem[a] = d;
                else    m_rdata[v.win] = v.rd;
                m_last = v.win;
                check({name, ".p0_rdata"}, p0_rdata_o, m_rdata[0]);
                check({name, ".p1_rdata"}, p1_rdata_o, m_rdata[1]);
                drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
            end
        end
        if (!got) check({name, ".ready_timeout"}, 32'd0, 32'd1);
        drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
        @(posedge clk_i); #1;
        check({name, ".idle_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        vec_t rv;
        int   grants, cyc, w, ew, k;
        bit   got;

        //            v0 we0 a0     d0            v1 we1 a1     d1            win lat rd
        tbl[0] = '{1, 1, 8'h05, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,        0, 2, 32'h0};
        tbl[1] = '{1, 0, 8'h05, 32'h0,        0, 0, 8'h00, 32'h0,        0, 3, 32'hDEADBEEF};
        tbl[2] = '{0, 0, 8'h00, 32'h0,        1, 1, 8'hFF, 32'h12345678, 1, 2, 32'h0};
        tbl[3] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'hFF, 32'h0,        1, 3, 32'h12345678};
        tbl[4] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h05, 32'h0,        1, 3, 32'hDEADBEEF};
        tbl[5] = '{1, 0, 8'hFF, 32'h0,        0, 0, 8'h00, 32'h0,        0, 3, 32'h12345678};
        tbl[6] = '{1, 1, 8'h10, 32'h11111111, 0, 0, 8'h00, 32'h0,        0, 2, 32'h0};
        tbl[7] = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h20, 32'h22222222, 1, 2, 32'h0};
        tbl[8] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h10, 32'h0,        1, 3, 32'h11111111};
        tbl[9] = '{1, 0, 8'h20, 32'h0,        0, 0, 8'h00, 32'h0,        0, 3, 32'h22222222};

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'd0;
            m_mem[i]   = 32'd0;
        end
        model_reset();
        drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);

        // Reset state
        rst_i = 1'b1;
        #1;
        check("rst.busy",  {31'd0, busy_o}, 32'd0);
        check("rst.ready", {30'd0, p0_ready_o, p1_ready_o}, 32'd0);
        check("rst.en",    {30'd0, ram_wr_en_o, ram_rd_en_o}, 32'd0);
        check("rst.addr",  {24'd0, ram_addr_o}, 32'd0);
        check("rst.di",    ram_di_o, 32'd0);
        check("rst.rdata", p0_rdata_o | p1_rdata_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Both ports requesting reads continuously; winner drops valid only in its ACK cycle
        drive(1, 0, 8'h10, 32'd0, 1, 0, 8'h20, 32'd0);
        grants = 0; cyc = 0;
        while (grants < 4 && cyc < 60) begin
            @(posedge clk_i); #1; cyc++;
            if (p0_ready_o || p1_ready_o) begin
                w  = p1_ready_o ? 1 : 0;
                ew = model_winner(1, 1);
                check($sformatf("contend.grant%0d", grants), w, ew);
                check("contend.both_ready", {31'd0, p0_ready_o & p1_ready_o}, 32'd0);
                m_rdata[w] = m_mem[(w == 1) ? 8'h20 : 8'h10];
                check("contend.rdata", (w == 1) ? p1_rdata_o : p0_rdata_o, m_rdata[w]);
                m_last = w;
                grants++;
                if (w == 0) p0_valid_i = 0; else p1_valid_i = 0;
            end else begin
                p0_valid_i = 1; p1_valid_i = 1;
            end
        end
        check("contend.grant_count", grants, 4);
        // Port 0 leaves; port 1 must then be served
        p0_valid_i = 0; p1_valid_i = 1;
        got = 0; cyc = 0;
        while (!got && cyc < 12) begin
            @(posedge clk_i); #1; cyc++;
            if (p0_ready_o || p1_ready_o) begin
                got = 1;
                if (p1_ready_o) m_rdata[1] = m_mem[8'h20];
                check("solo_p1.grant", {31'd0, p1_ready_o}, 32'd1);
                check("solo_p1.rdata", p1_rdata_o, m_rdata[1]);
                m_last = 1;
            end
        end
        if (!got) check("solo_p1.timeout", 32'd0, 32'd1);
        drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
        @(posedge clk_i); #1;

        // Late arrival: p1 write appears while p0 read is in CAPTURE
        drive(1, 0, 8'h05, 32'd0, 0, 0, 8'd0, 32'd0);
        for (k = 1; k <= 7; k++) begin
            @(posedge clk_i); #1;
            if (k == 2) begin
                p1_valid_i = 1; p1_we_i = 1; p1_addr_i = 8'hFF; p1_wdata_i = 32'h12345678;
            end
            if (k < 6) check($sformatf("late.p1_ready_k%0d", k), {31'd0, p1_ready_o}, 32'd0);
            if (k == 3) begin
                check("late.p0_ready", {31'd0, p0_ready_o}, 32'd1);
                m_rdata[0] = m_mem[8'h05];
                check("late.p0_rdata", p0_rdata_o, m_rdata[0]);
                p0_valid_i = 0;
            end
            if (k == 4) check("late.idle_gap", {31'd0, busy_o}, 32'd0);
            if (k == 5) begin
                check("late.wr_en", {31'd0, ram_wr_en_o}, 32'd1);
                check("late.addr",  {24'd0, ram_addr_o}, 32'h000000FF);
                check("late.di",    ram_di_o, 32'h12345678);
            end
            if (k == 6) begin
                check("late.p1_ready", {31'd0, p1_ready_o}, 32'd1);
                m_mem[8'hFF] = 32'h12345678;
                m_last = 1;
                p1_valid_i = 0;
            end
        end

        // Reset asserted while a read sits in CAPTURE
        drive(1, 0, 8'h05, 32'd0, 0, 0, 8'd0, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("midrst.in_capture", {31'd0, ram_rd_en_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("midrst.busy",  {31'd0, busy_o}, 32'd0);
        check("midrst.ready", {30'd0, p0_ready_o, p1_ready_o}, 32'd0);
        check("midrst.en",    {30'd0, ram_wr_en_o, ram_rd_en_o}, 32'd0);
        check("midrst.addr",  {24'd0, ram_addr_o}, 32'd0);
        check("midrst.rdata", p0_rdata_o | p1_rdata_o, 32'd0);
        drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_txn('{1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0, 0, 3, m_mem[8'h05]}, "post_rst_read");

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            rv.v0  = $urandom_range(0, 1);
            rv.v1  = rv.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.we0 = $urandom_range(0, 1);
            rv.we1 = $urandom_range(0, 1);
            rv.a0  = 8'($urandom_range(0, 15));
            rv.a1  = 8'($urandom_range(0, 15));
            rv.d0  = $urandom;
            rv.d1  = $urandom;
            rv.win = model_winner(rv.v0, rv.v1);
            rv.lat = ((rv.win == 1) ? rv.we1 : rv.we0) ? 2 : 3;
            rv.rd  = m_mem[(rv.win == 1) ? rv.a1 : rv.a0];
            run_txn(rv, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
